gray_period_ctrl: RTL
=====================

# gray_period_ctrl

Sequencing controller for a gray-code period counter. It accepts a start request with a terminal count and a repetition count, then runs the counter through that many periods. Each rollover produces a wrap pulse, and completion or abort is reported with a one-cycle done pulse. It sits between a host or config register block and any logic that consumes gray_cnt and the wrap strobe.

## Interface
- CBITS, 8, width of counter and terminal count
- RBITS, 8, width of repetition count and rep counter
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a run; sampled only in IDLE
- stop  in  1  abort request; sampled in LOAD and RUN
- cfg_term  in  CBITS  binary terminal count; period = cfg_term+1 cycles
- cfg_reps  in  RBITS  periods to run; 0 = free-run until stop
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse in the DONE state
- aborted  out  1  run ended by stop; held until next LOAD
- wrap  out  1  one-cycle pulse when the counter rolls over to 0
- gray_cnt  out  CBITS  bin ^ (bin >> 1) of the internal binary count
- rep_cnt  out  RBITS  completed periods in the current or last run

## Operation
- States are IDLE, LOAD, RUN and DONE; the state register is binary encoded.
- IDLE
  - Counter is held at its current value.
  - start=1 and stop=0 moves to LOAD.
  - start=1 together with stop=1 is ignored.
- LOAD
  - Latches cfg_term into term_q and cfg_reps into reps_q.
  - Clears bin, rep_cnt and aborted.
  - Moves to RUN unless stop=1, which moves to DONE with aborted set.
- RUN
  - bin increments by 1 each cycle.
  - When bin == term_q: next bin = 0, wrap=1 in the next cycle, and rep_cnt increments, wrapping mod 2^RBITS.
  - If additionally reps_q != 0 and rep_cnt+1 == reps_q, the next state is DONE; otherwise the state stays RUN.
- DONE: done=1 for one cycle, then IDLE.
- stop in RUN
  - Next state is DONE with aborted=1.
  - bin freezes; there is no wrap and no rep_cnt increment, even if bin == term_q in the same cycle (stop has priority).
- start while busy is ignored, and so is start in DONE.
- cfg_term and cfg_reps changing during a run have no effect, because the latched copies are used.
- term_q = 0 gives a 1-cycle period, so wrap is high every RUN cycle after the first.
- rst forces IDLE from any state, including mid-run.
  - Outputs after reset: busy, done, aborted, wrap all 0; gray_cnt 0; rep_cnt 0.
  - term_q and reps_q also reset to 0.

## Timing
- start sampled high at edge t:
  - LOAD at t+1 (busy=1, bin=0).
  - RUN at t+2 with bin=0.
  - bin equals term_q at t+2+term_q.
  - wrap and bin=0 at t+3+term_q.
- gray_cnt has zero latency from bin, so it returns to 0 in the same cycle wrap is high.
- Final period: wrap and done are high in the same (DONE) cycle; busy is low in that cycle.
- Total run, start edge to done cycle: 2 + reps*(term+1) + 1 cycles.
- stop sampled at edge s in RUN: done=1 at s+1 and aborted=1 from s+1.
- wrap, done and busy are registered outputs with no combinational path from inputs.

## Structure
- Package gray_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the function bin2gray(bin), parameterised by width via a CBITS localparam default.
- Sub-module gray_counter (CBITS) holds the binary register.
  - Inputs: clk, rst, en, clr, term.
  - Outputs: gray, at_term = (bin == term).
- gray_period_ctrl holds the FSM, term_q, reps_q, rep_cnt and the wrap/done/aborted flags.

## Test plan
- Reset mid-run: run with term=5, reps=0, assert rst at RUN cycle 3 -> next cycle all outputs 0, state IDLE, no done.
- Basic run: term=3, reps=2, start at t.
  - gray_cnt sequence 0,1,3,2,0,1,3,2,0 starting t+2.
  - wrap at t+6 and t+10; done at t+10 with rep_cnt=2, aborted=0; busy low from t+10.
- term=0, reps=4 -> wrap high 4 cycles, first at t+3; done at t+6 coinciding with the 4th wrap; gray_cnt stays 0.
- Free-run with abort: term=255, reps=0.
  - Run 600 cycles: rep_cnt=2, wraps at 256-cycle spacing.
  - stop at a bin==255 edge -> no wrap, done the next cycle, aborted=1, rep_cnt unchanged.
- Ignored inputs:
  - start during RUN and during DONE has no effect; a start+stop pair in IDLE stays IDLE.
  - Changing cfg_term mid-run keeps the original period.
- stop in LOAD: start then stop on the next edge -> DONE at t+2, aborted=1, rep_cnt=0, no wrap.

Source files
------------

// File: rtl/gray_period_ctrl_pkg.sv
// Shared types and helpers for the gray-code period controller.
// Holds the FSM state encoding and the binary-to-gray conversion.
package gray_pkg;

    localparam int CBITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [CBITS-1:0] bin2gray(input logic [CBITS-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_period_ctrl_if.sv
// Host-side bundle for gray_period_ctrl: run request/config in, status and
// counter outputs back.
interface gray_period_ctrl_if #(
    parameter int CBITS = 8,
    parameter int RBITS = 8
);
    logic             start;
    logic             stop;
    logic [CBITS-1:0] cfg_term;
    logic [RBITS-1:0] cfg_reps;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             wrap;
    logic [CBITS-1:0] gray_cnt;
    logic [RBITS-1:0] rep_cnt;

    modport master (
        output start, stop, cfg_term, cfg_reps,
        input  busy, done, aborted, wrap, gray_cnt, rep_cnt
    );

    modport slave (
        input  start, stop, cfg_term, cfg_reps,
        output busy, done, aborted, wrap, gray_cnt, rep_cnt
    );
endinterface

// File: rtl/gray_period_ctrl_counter.sv
// Binary period counter with gray-coded view; rolls over to 0 after term.
// clr wins over en so a new run always starts from 0.
module gray_counter #(
    parameter int CBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CBITS-1:0] term,
    output logic [CBITS-1:0] gray,
    output logic             at_term
);
    import gray_pkg::*;

    logic [CBITS-1:0] bin;

    assign at_term = (bin == term);

    always_ff @(posedge clk) begin
        if (rst)
            bin <= '0;
        else if (clr)
            bin <= '0;
        else if (en)
            bin <= at_term ? '0 : bin + CBITS'(1);
    end

    // The package helper is fixed-width; other widths use the same formula inline.
    generate
        if (CBITS == gray_pkg::CBITS) begin : g_pkg
            assign gray = bin2gray(bin);
        end else begin : g_inline
            assign gray = bin ^ (bin >> 1);
        end
    endgenerate

endmodule

// File: rtl/gray_period_ctrl.sv
// Sequencer that runs a gray-code counter for a set number of periods,
// strobing wrap on each rollover and done on completion or abort.
module gray_period_ctrl #(
    parameter int CBITS = 8,
    parameter int RBITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    gray_period_ctrl_if.slave  bus
);
    import gray_pkg::*;

    state_t           state, state_nxt;
    logic [CBITS-1:0] term_q;
    logic [RBITS-1:0] reps_q;
    logic [RBITS-1:0] rep_cnt_q;
    logic             wrap_q;
    logic             aborted_q;
    logic             at_term;
    logic             go;
    logic             adv;
    logic             last_rep;

    // go clears the counter on entry to LOAD so bin already reads 0 there.
    assign go       = (state == IDLE) && bus.start && !bus.stop;
    assign adv      = (state == RUN) && !bus.stop && at_term;
    assign last_rep = (reps_q != '0) && ((rep_cnt_q + RBITS'(1)) == reps_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = LOAD;
            LOAD:    state_nxt = bus.stop ? DONE : RUN;
            RUN:     if (bus.stop || (adv && last_rep)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            term_q    <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            wrap_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            wrap_q <= adv;
            if (state == LOAD) begin
                term_q <= bus.cfg_term;
                reps_q <= bus.cfg_reps;
            end
            if (go)
                rep_cnt_q <= '0;
            else if (adv)
                rep_cnt_q <= rep_cnt_q + RBITS'(1);
            if (go)
                aborted_q <= 1'b0;
            else if ((state == LOAD || state == RUN) && bus.stop)
                aborted_q <= 1'b1;
        end
    end

    gray_counter #(.CBITS(CBITS)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == RUN) && !bus.stop),
        .clr     (go),
        .term    (term_q),
        .gray    (bus.gray_cnt),
        .at_term (at_term)
    );

    assign bus.busy    = (state == LOAD) || (state == RUN);
    assign bus.done    = (state == DONE);
    assign bus.wrap    = wrap_q;
    assign bus.aborted = aborted_q;
    assign bus.rep_cnt = rep_cnt_q;

endmodule
